// File: rtl/cfg_bus_arbiter_pkg.sv
// Shared types and constants for the configuration bus arbiter.
// Covers the slave select codes, the FSM states and the bus write payload.
package cfg_bus_arbiter_pkg;

  localparam int unsigned WIDTH_CONFIG_ADDR = 4;
  localparam int unsigned WIDTH_CONFIG_DATA = 8;
  localparam int unsigned WIDTH_WAIT        = 8;

  localparam logic [1:0] CFG_SEL_UART = 2'b01;
  localparam logic [1:0] CFG_SEL_VGA  = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT0 = 2'd0,
    ST_BOOT1 = 2'd1,
    ST_RUN   = 2'd2
  } cfg_state_e;

  typedef struct packed {
    logic [WIDTH_CONFIG_ADDR-1:0] addr;
    logic [WIDTH_CONFIG_DATA-1:0] data;
  } cfg_wr_t;

  // Only the UART and VGA windows decode to a real slave.
  function automatic logic cfg_addr_legal(input logic [WIDTH_CONFIG_ADDR-1:0] addr);
    return (addr[3:2] == CFG_SEL_UART) || (addr[3:2] == CFG_SEL_VGA);
  endfunction

endpackage

// File: rtl/cfg_rr_arb2.sv
// Two-way round-robin grant for the config bus requesters (A = host, B = debug).
// The pointer remembers the last requester that actually completed a handshake.
module cfg_rr_arb2
  import cfg_bus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  input  logic upd_b,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  // 0 = A was served last, 1 = B was served last
  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    gnt_a_c  = 1'b0;
    gnt_b_c  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (req_a && req_b) begin
      gnt_a_c = rr_ptr_q;
      gnt_b_c = ~rr_ptr_q;
    end else begin
      gnt_a_c = req_a;
      gnt_b_c = req_b;
    end
    if (upd) begin
      rr_ptr_d = upd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Owns the UART/VGA config bus: runs the boot writes, then shares the bus between
// requesters A and B, dropping illegal addresses and writes stalled past TIMEOUT.
module cfg_bus_arbiter
  import cfg_bus_arbiter_pkg::*;
#(
  parameter logic [WIDTH_CONFIG_ADDR-1:0] BOOT_UART_ADDR = 4'b0100,
  parameter logic [WIDTH_CONFIG_DATA-1:0] BOOT_UART_DATA = 8'h00,
  parameter logic [WIDTH_CONFIG_ADDR-1:0] BOOT_VGA_ADDR  = 4'b1000,
  parameter logic [WIDTH_CONFIG_DATA-1:0] BOOT_VGA_DATA  = 8'h00,
  parameter int unsigned                  TIMEOUT        = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_CONFIG_ADDR-1:0] a_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] a_data,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [WIDTH_CONFIG_ADDR-1:0] b_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] b_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic                         busy,
  output logic                         err_addr,
  output logic                         err_timeout
);

  cfg_state_e             state_q, state_d;
  cfg_wr_t                wr_q, wr_d;
  logic                   c_valid_q, c_valid_d;
  logic                   a_ready_q, a_ready_d;
  logic                   b_ready_q, b_ready_d;
  logic                   err_addr_q, err_addr_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   busy_q, busy_d;
  logic [WIDTH_WAIT-1:0]  wait_cnt_q, wait_cnt_d;

  logic                   gnt_a_c, gnt_b_c;
  logic                   hs_a, hs_b, arb_upd;
  logic                   accept, stall, expire, done;
  cfg_wr_t                req_wr_c;

  assign hs_a     = a_ready_q & a_valid;
  assign hs_b     = b_ready_q & b_valid;
  assign arb_upd  = (state_q == ST_RUN) & ~c_valid_q & (hs_a | hs_b);
  assign req_wr_c = hs_b ? cfg_wr_t'{addr: b_addr, data: b_data}
                         : cfg_wr_t'{addr: a_addr, data: a_data};

  // A c_ready in the final wait cycle wins over the timeout.
  assign accept = c_valid_q & c_ready;
  assign stall  = c_valid_q & ~c_ready;
  assign expire = stall & (wait_cnt_q == WIDTH_WAIT'(TIMEOUT - 1));
  assign done   = accept | expire;

  cfg_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (a_valid),
    .req_b   (b_valid),
    .upd     (arb_upd),
    .upd_b   (hs_b),
    .gnt_a_c (gnt_a_c),
    .gnt_b_c (gnt_b_c)
  );

  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    c_valid_d     = c_valid_q;
    a_ready_d     = 1'b0;
    b_ready_d     = 1'b0;
    err_addr_d    = 1'b0;
    err_timeout_d = expire;
    wait_cnt_d    = stall ? (wait_cnt_q + WIDTH_WAIT'(1)) : wait_cnt_q;

    unique case (state_q)
      ST_BOOT0: begin
        if (!c_valid_q) begin
          wr_d       = '{addr: BOOT_UART_ADDR, data: BOOT_UART_DATA};
          c_valid_d  = 1'b1;
          wait_cnt_d = '0;
        end else if (done) begin
          wr_d       = '{addr: BOOT_VGA_ADDR, data: BOOT_VGA_DATA};
          wait_cnt_d = '0;
          state_d    = ST_BOOT1;
        end
      end
      ST_BOOT1: begin
        if (done) begin
          c_valid_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (c_valid_q) begin
          if (done) begin
            c_valid_d = 1'b0;
          end
        end else if (hs_a || hs_b) begin
          // Illegal payloads are still latched but never presented to the slaves.
          wr_d       = req_wr_c;
          c_valid_d  = cfg_addr_legal(req_wr_c.addr);
          err_addr_d = ~cfg_addr_legal(req_wr_c.addr);
          wait_cnt_d = '0;
        end else if (!err_addr_q && !err_timeout_q) begin
          a_ready_d = gnt_a_c;
          b_ready_d = gnt_b_c;
        end
      end
      default: begin
        state_d = ST_BOOT0;
      end
    endcase

    busy_d = (state_d != ST_RUN) | c_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT0;
      wr_q          <= '0;
      c_valid_q     <= 1'b0;
      a_ready_q     <= 1'b0;
      b_ready_q     <= 1'b0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b1;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      c_valid_q     <= c_valid_d;
      a_ready_q     <= a_ready_d;
      b_ready_q     <= b_ready_d;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign c_addr      = wr_q.addr;
  assign c_data      = wr_q.data;
  assign c_valid     = c_valid_q;
  assign a_ready     = a_ready_q;
  assign b_ready     = b_ready_q;
  assign busy        = busy_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Bench for cfg_bus_arbiter: a transaction-level model is compared against the DUT
// every cycle, and directed literal expectations pin the key boot/grant/error events.
module tb_cfg_bus_arbiter;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       c_ready = 1'b1;
  logic       a_ready, b_ready, c_valid, busy, err_addr, err_timeout;
  logic [3:0] c_addr;
  logic [7:0] c_data;

  int checks = 0;
  int errors = 0;

  cfg_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .c_addr      (c_addr),
    .c_data      (c_data),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .busy        (busy),
    .err_addr    (err_addr),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: boot phase (0 = first write, 1 = second write, 2 = done),
  // pending bus write, stall count, offered requester (0 none, 1 A, 2 B), last served.
  int         m_boot, m_wait, m_ready, m_last;
  logic       m_valid, m_err_a, m_err_t;
  logic [3:0] m_addr;
  logic [7:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    int         bt, wt, rd, ls, took;
    logic       v, ea, et, fin;
    logic [3:0] ad;
    logic [7:0] dt;
    if (!rst_n) begin
      m_boot <= 0; m_wait <= 0; m_ready <= 0; m_last <= 1;
      m_valid <= 1'b0; m_err_a <= 1'b0; m_err_t <= 1'b0;
      m_addr <= '0; m_data <= '0;
    end else begin
      bt = m_boot; wt = m_wait; ls = m_last; v = m_valid; ad = m_addr; dt = m_data;
      rd = 0; ea = 1'b0; et = 1'b0; fin = 1'b0; took = 0;
      if (m_valid) begin
        if (c_ready) fin = 1'b1;
        else begin
          wt = wt + 1;
          if (wt == TIMEOUT) begin fin = 1'b1; et = 1'b1; end
        end
        if (fin) begin
          if (bt == 0) begin ad = 4'b1000; dt = 8'h00; bt = 1; wt = 0; end
          else begin v = 1'b0; if (bt == 1) bt = 2; end
        end
      end else if (bt == 0) begin
        ad = 4'b0100; dt = 8'h00; v = 1'b1; wt = 0;
      end else if (bt == 2) begin
        if (m_ready == 1 && a_valid) took = 1;
        else if (m_ready == 2 && b_valid) took = 2;
        if (took != 0) begin
          ad = (took == 1) ? a_addr : b_addr;
          dt = (took == 1) ? a_data : b_data;
          ls = took;
          if (ad[3:2] == 2'b01 || ad[3:2] == 2'b10) begin v = 1'b1; wt = 0; end
          else ea = 1'b1;
        end else if (!m_err_a && !m_err_t) begin
          if (a_valid && b_valid) rd = (m_last == 1) ? 2 : 1;
          else if (a_valid) rd = 1;
          else if (b_valid) rd = 2;
        end
      end
      m_boot <= bt; m_wait <= wt; m_ready <= rd; m_last <= ls;
      m_valid <= v; m_err_a <= ea; m_err_t <= et; m_addr <= ad; m_data <= dt;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("c_valid", c_valid, m_valid);
      chk("c_addr", c_addr, m_addr);
      chk("c_data", c_data, m_data);
      chk("a_ready", a_ready, m_ready == 1);
      chk("b_ready", b_ready, m_ready == 2);
      chk("busy", busy, (m_boot != 2) || m_valid);
      chk("err_addr", err_addr, m_err_a);
      chk("err_timeout", err_timeout, m_err_t);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic boot_check(input string tag);
    @(negedge clk);
    chk({tag, "_boot0_valid"}, c_valid, 1'b1);
    chk({tag, "_boot0_addr"}, c_addr, 4'b0100);
    chk({tag, "_boot0_data"}, c_data, 8'h00);
    @(negedge clk);
    chk({tag, "_boot1_valid"}, c_valid, 1'b1);
    chk({tag, "_boot1_addr"}, c_addr, 4'b1000);
    chk({tag, "_boot_busy_hi"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, "_boot_done_valid"}, c_valid, 1'b0);
    chk({tag, "_boot_busy_lo"}, busy, 1'b0);
    chk({tag, "_boot_no_err"}, {err_addr, err_timeout}, 2'b00);
  endtask

  // Waits (bounded) until the chosen requester sees ready; 1 = A, 2 = B.
  task automatic wait_rdy(input int who, input string name);
    int n = 0;
    while (((who == 1) ? a_ready : b_ready) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, (who == 1) ? a_ready : b_ready, 1'b1);
  endtask

  initial begin
    int   grants[$];
    int   ia, ib, n;
    logic pa, pb;

    // Test 1: reset state and boot sequence
    repeat (2) @(negedge clk);
    chk("rst_c_valid", c_valid, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_readies", {a_ready, b_ready}, 2'b00);
    chk("rst_c_addr", c_addr, 4'h0);
    rst_n = 1'b1;
    boot_check("t1");

    // Test 2: single A request
    a_valid = 1'b1; a_addr = 4'b0101; a_data = 8'h03;
    @(negedge clk);
    chk("t2_a_ready", a_ready, 1'b1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("t2_c_valid", c_valid, 1'b1);
    chk("t2_c_addr", c_addr, 4'b0101);
    chk("t2_c_data", c_data, 8'h03);
    chk("t2_a_ready_lo", a_ready, 1'b0);
    @(negedge clk);
    chk("t2_c_valid_lo", c_valid, 1'b0);

    // Test 3: both requesters held, round-robin alternation
    ia = 0; ib = 0; pa = 1'b0; pb = 1'b0;
    a_valid = 1'b1; a_addr = 4'b0101; a_data = 8'hA0;
    b_valid = 1'b1; b_addr = 4'b1001; b_data = 8'hB0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (pa) begin ia++; a_data = 8'hA0 + 8'(ia); end
      if (pb) begin ib++; b_data = 8'hB0 + 8'(ib); end
      pa = (a_ready === 1'b1);
      pb = (b_ready === 1'b1);
      if (pa) grants.push_back(1);
      if (pb) grants.push_back(2);
      if (grants.size() >= 4) break;
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      chk($sformatf("t3_grant%0d", i), grants[i], (i % 2 == 0) ? 2 : 1);
    repeat (3) @(negedge clk);

    // Test 4: illegal address from A
    a_valid = 1'b1; a_addr = 4'b1100; a_data = 8'h5A;
    wait_rdy(1, "t4_a_ready");
    @(negedge clk);
    a_valid = 1'b0;
    chk("t4_err_addr", err_addr, 1'b1);
    chk("t4_c_valid", c_valid, 1'b0);
    @(negedge clk);
    chk("t4_err_addr_lo", err_addr, 1'b0);
    chk("t4_c_valid_lo", c_valid, 1'b0);

    // Test 5a: stalled write times out
    c_ready = 1'b0;
    a_valid = 1'b1; a_addr = 4'b1000; a_data = 8'h7E;
    wait_rdy(1, "t5_a_ready");
    @(negedge clk);
    a_valid = 1'b0;
    chk("t5_c_valid", c_valid, 1'b1);
    n = 0;
    while (n < TIMEOUT + 10) begin
      @(negedge clk);
      n++;
      if (err_timeout === 1'b1) break;
    end
    chk("t5_timeout_cycles", n, TIMEOUT);
    chk("t5_c_valid_dropped", c_valid, 1'b0);
    chk("t5_busy_lo", busy, 1'b0);

    // Test 5b: c_ready in the last wait cycle is an acceptance
    a_valid = 1'b1; a_addr = 4'b0111; a_data = 8'h99;
    wait_rdy(1, "t5b_a_ready");
    @(negedge clk);
    a_valid = 1'b0;
    chk("t5b_c_valid", c_valid, 1'b1);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("t5b_still_valid", c_valid, 1'b1);
    c_ready = 1'b1;
    @(negedge clk);
    chk("t5b_no_timeout", err_timeout, 1'b0);
    chk("t5b_c_valid_lo", c_valid, 1'b0);

    // Test 6: async reset mid-transfer, from a B request
    c_ready = 1'b0;
    b_valid = 1'b1; b_addr = 4'b0110; b_data = 8'h42;
    wait_rdy(2, "t6_b_ready");
    @(negedge clk);
    b_valid = 1'b0;
    chk("t6_c_valid", c_valid, 1'b1);
    chk("t6_c_data", c_data, 8'h42);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_c_valid", c_valid, 1'b0);
    chk("t6_async_busy", busy, 1'b1);
    chk("t6_async_c_addr", c_addr, 4'h0);
    @(negedge clk);
    c_ready = 1'b1;
    rst_n = 1'b1;
    boot_check("t6");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
